// File: rtl/blob_binarizer_if.sv
// Pixel stream bundle between the camera front end and blob_binarizer.
// The master drives the RGB beats; the slave returns the filtered bit stream.
interface blob_binarizer_if #(
  parameter int PIX_W = 10
);
  logic             i_valid;
  logic             i_sof;
  logic [PIX_W-1:0] i_red;
  logic [PIX_W-1:0] i_green;
  logic [PIX_W-1:0] i_blue;
  logic [PIX_W-1:0] i_threshold;
  logic             i_invert;
  logic             o_valid;
  logic             o_seq;
  logic             o_sof;
  logic             o_eof;
  logic             o_busy;

  modport master (
    output i_valid, i_sof, i_red, i_green, i_blue, i_threshold, i_invert,
    input  o_valid, o_seq, o_sof, o_eof, o_busy
  );

  modport slave (
    input  i_valid, i_sof, i_red, i_green, i_blue, i_threshold, i_invert,
    output o_valid, o_seq, o_sof, o_eof, o_busy
  );
endinterface

// File: rtl/blob_binarizer.sv
// RGB -> gray -> threshold -> 3x3 majority filter, emitting one bit per pixel in raster order.
// A bit history of two lines plus three pixels provides the full window around each output.
module blob_binarizer #(
  parameter int IMG_COL = 640,
  parameter int IMG_ROW = 480,
  parameter int PIX_W   = 10
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  blob_binarizer_if.slave bus
);
  localparam int TOTAL = IMG_COL * IMG_ROW;
  localparam int IDX_W = $clog2(TOTAL);
  localparam int COL_W = $clog2(IMG_COL);
  localparam int ROW_W = $clog2(IMG_ROW);
  localparam int HIST  = 2 * IMG_COL + 2;
  localparam logic [IDX_W-1:0] FIRST_OUT = IDX_W'(IMG_COL + 1);
  localparam logic [IDX_W-1:0] LAST_IN   = IDX_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_COL - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_ROW - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] in_idx, cur_idx;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic [PIX_W-1:0] thr_r, thr_use;
  logic             inv_r, inv_use;
  logic [HIST-1:0]  hist;
  logic [HIST:0]    stream;
  logic [PIX_W+1:0] gray_sum;
  logic [8:0]       window;
  logic             accept, restart, shift, emit, last_out, pix_bit, filt_bit;
  logic             top_ok, bot_ok, left_ok, right_ok;

  function automatic logic majority9(input logic [8:0] w);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 9; i++) begin
      cnt = cnt + {3'd0, w[i]};
    end
    return (cnt >= 4'd5);
  endfunction

  // next-state, beat acceptance and window assembly
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    restart    = 1'b0;
    last_out   = (out_row == LAST_ROW) && (out_col == LAST_COL);
    case (state)
      IDLE: begin
        if (bus.i_valid && bus.i_sof) begin
          accept     = 1'b1;
          restart    = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (bus.i_valid) begin
          accept     = 1'b1;
          restart    = bus.i_sof;
          next_state = (!bus.i_sof && (in_idx == LAST_IN)) ? FLUSH : RUN;
        end else begin
          next_state = RUN;
        end
      end
      FLUSH: begin
        next_state = last_out ? IDLE : FLUSH;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    shift    = accept || (state == FLUSH);
    cur_idx  = restart ? '0 : in_idx;
    thr_use  = restart ? bus.i_threshold : thr_r;
    inv_use  = restart ? bus.i_invert : inv_r;
    gray_sum = {2'b00, bus.i_red} + {1'b0, bus.i_green, 1'b0} + {2'b00, bus.i_blue};
    pix_bit  = accept && ((gray_sum[PIX_W+1:2] >= thr_use) ^ inv_use);
    stream   = {hist, pix_bit};
    emit     = (state == FLUSH) || (accept && !restart && (cur_idx >= FIRST_OUT));

    // Newest bit is the bottom-right neighbour of the output pixel; masks stop edge wrap.
    top_ok   = (out_row != '0);
    bot_ok   = (out_row != LAST_ROW);
    left_ok  = (out_col != '0);
    right_ok = (out_col != LAST_COL);
    window   = {stream[2*IMG_COL+2] & top_ok & left_ok,
                stream[2*IMG_COL+1] & top_ok,
                stream[2*IMG_COL]   & top_ok & right_ok,
                stream[IMG_COL+2]   & left_ok,
                stream[IMG_COL+1],
                stream[IMG_COL]     & right_ok,
                stream[2]           & bot_ok & left_ok,
                stream[1]           & bot_ok,
                stream[0]           & bot_ok & right_ok};
    filt_bit = majority9(window);
  end

  // state, counters, history and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      in_idx      <= '0;
      out_row     <= '0;
      out_col     <= '0;
      thr_r       <= '0;
      inv_r       <= 1'b0;
      hist        <= '0;
      bus.o_valid <= 1'b0;
      bus.o_seq   <= 1'b0;
      bus.o_sof   <= 1'b0;
      bus.o_eof   <= 1'b0;
    end else begin
      state <= next_state;
      if (restart) begin
        thr_r <= bus.i_threshold;
        inv_r <= bus.i_invert;
      end
      if (accept) begin
        in_idx <= cur_idx + IDX_W'(1);
      end
      if (shift) begin
        hist <= stream[HIST-1:0];
      end
      if (restart) begin
        out_row <= '0;
        out_col <= '0;
      end else if (emit) begin
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= (out_row == LAST_ROW) ? '0 : out_row + ROW_W'(1);
        end else begin
          out_col <= out_col + COL_W'(1);
        end
      end
      bus.o_valid <= emit;
      bus.o_seq   <= emit && filt_bit;
      bus.o_sof   <= emit && (out_row == '0) && (out_col == '0);
      bus.o_eof   <= emit && last_out;
    end
  end

  assign bus.o_busy = (state == FLUSH);
endmodule

// File: tb/tb_blob_binarizer.sv
// Self-checking bench for blob_binarizer on an 8x6 frame: a 2-D image model predicts
// every output cycle; literal frame signatures pin the model on the directed patterns.
module tb_blob_binarizer;
  localparam int C = 8;
  localparam int R = 6;
  localparam int PW = 10;
  localparam int TOTAL = C * R;
  localparam logic [63:0] WHITE = 64'h0000_7EFF_FFFF_FF7E;
  localparam logic [63:0] PLUS  = 64'h0000_0008_1C08_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  blob_binarizer_if #(.PIX_W(PW)) bus ();

  blob_binarizer #(.IMG_COL(C), .IMG_ROW(R), .PIX_W(PW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state: 0 idle, 1 receiving, 2 flushing
  int m_mode = 0;
  int m_k = 0;
  int m_fj = 0;
  int m_thr = 0;
  bit m_inv = 1'b0;
  bit img [R][C];
  bit exp_valid = 1'b0, exp_seq = 1'b0, exp_sof = 1'b0, exp_eof = 1'b0, exp_busy = 1'b0;

  int t_beats, t_ones, t_sof_cnt, t_sof_idx, t_eof_cnt, t_eof_idx, t_busy, t_busy_valid;
  logic [63:0] t_vec;

  function automatic bit filt(int j);
    int rr, cc, n;
    rr = j / C;
    cc = j % C;
    n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (rr + dr >= 0 && rr + dr < R && cc + dc >= 0 && cc + dc < C && img[rr+dr][cc+dc])
          n++;
    return n >= 5;
  endfunction

  task automatic emit_exp(int j);
    exp_valid = 1'b1;
    exp_seq   = filt(j);
    exp_sof   = (j == 0);
    exp_eof   = (j == TOTAL - 1);
  endtask

  task automatic model_step(bit v, bit s, int rd, int gr, int bl, int thr, bit inv);
    exp_valid = 1'b0; exp_seq = 1'b0; exp_sof = 1'b0; exp_eof = 1'b0;
    if (m_mode == 2) begin
      emit_exp(m_fj);
      if (m_fj == TOTAL - 1) m_mode = 0;
      else m_fj++;
    end else if (v && (s || m_mode == 1)) begin
      if (s) begin
        m_thr = thr;
        m_inv = inv;
        m_k = 0;
        m_mode = 1;
        foreach (img[i, j]) img[i][j] = 1'b0;
      end
      img[m_k / C][m_k % C] = (((rd + 2 * gr + bl) / 4) >= m_thr) != m_inv;
      if (m_k >= C + 1) emit_exp(m_k - C - 1);
      if (m_k == TOTAL - 1) begin
        m_mode = 2;
        m_fj = m_k - C;
      end else begin
        m_k++;
      end
    end
    exp_busy = (m_mode == 2);
  endtask

  task automatic drive_cycle(bit v, bit s, int rd, int gr, int bl, int thr, bit inv);
    @(negedge clk);
    bus.i_valid     = v;
    bus.i_sof       = s;
    bus.i_red       = PW'(rd);
    bus.i_green     = PW'(gr);
    bus.i_blue      = PW'(bl);
    bus.i_threshold = PW'(thr);
    bus.i_invert    = inv;
    model_step(v, s, rd, gr, bl, thr, inv);
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
  endtask

  task automatic pixel(int pat, int rr, int cc, output int rd, output int gr, output int bl);
    case (pat)
      0: begin rd = 1023; gr = 1023; bl = 1023; end
      1: begin rd = (rr == 3 && cc == 4) ? 1023 : 0; gr = rd; bl = rd; end
      2: begin rd = (rr >= 2 && rr <= 4 && cc >= 2 && cc <= 4) ? 1023 : 0; gr = rd; bl = rd; end
      3: begin rd = 512; gr = 512; bl = 512; end
      default: begin
        rd = $urandom_range(0, 1023); gr = $urandom_range(0, 1023); bl = $urandom_range(0, 1023);
      end
    endcase
  endtask

  // gap: 0 back-to-back, 1 alternate cycles, 2 random; stop_at >= 0 sends only that many beats
  task automatic send_frame(int pat, int thr, bit inv, int gap, int stop_at, bit pulse);
    int nb, rd, gr, bl, budget;
    nb = (stop_at >= 0) ? stop_at : TOTAL;
    for (int k = 0; k < nb; k++) begin
      pixel(pat, k / C, k % C, rd, gr, bl);
      if (k == 0) drive_cycle(1'b1, 1'b1, rd, gr, bl, thr, inv);
      else drive_cycle(1'b1, 1'b0, rd, gr, bl, $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
      if (k != nb - 1) begin
        if (gap == 1) idle_cycle();
        else if (gap == 2) repeat ($urandom_range(0, 2)) idle_cycle();
      end
    end
    if (stop_at < 0) begin
      budget = 0;
      while (m_mode != 0 && budget < 4 * C) begin
        pixel(4, 0, 0, rd, gr, bl);
        drive_cycle(pulse ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1, rd, gr, bl, 0, 1'b0);
        budget++;
      end
      checks++;
      if (m_mode != 0) begin
        errors++;
        $display("FAIL flush_bound: model still flushing after %0d cycles, required done", budget);
      end
      idle_cycle();
      idle_cycle();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sof = 1'b0;
    m_mode = 0;
    exp_valid = 1'b0; exp_seq = 1'b0; exp_sof = 1'b0; exp_eof = 1'b0; exp_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // starts a fresh tally just after the compare of the next edge
  task automatic clear_tally();
    @(posedge clk);
    #2;
    t_beats = 0; t_ones = 0; t_sof_cnt = 0; t_sof_idx = -1; t_eof_cnt = 0; t_eof_idx = -1;
    t_busy = 0; t_busy_valid = 0; t_vec = 64'd0;
  endtask

  task automatic check(string name, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_vec(string name, logic [63:0] got, logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // per-cycle comparison against the model plus frame tallies
  always @(posedge clk) begin
    #1;
    cyc++;
    checks++;
    if ({bus.o_valid, bus.o_seq, bus.o_sof, bus.o_eof, bus.o_busy} !==
        {exp_valid, exp_seq, exp_sof, exp_eof, exp_busy}) begin
      errors++;
      $display("FAIL outputs cycle %0d: got valid/seq/sof/eof/busy=%b required %b", cyc,
               {bus.o_valid, bus.o_seq, bus.o_sof, bus.o_eof, bus.o_busy},
               {exp_valid, exp_seq, exp_sof, exp_eof, exp_busy});
    end
    if (bus.o_busy === 1'b1) begin
      t_busy++;
      if (bus.o_valid === 1'b1) t_busy_valid++;
    end
    if (bus.o_valid === 1'b1) begin
      if (t_beats < 64) t_vec[t_beats] = bus.o_seq;
      if (bus.o_seq === 1'b1) t_ones++;
      if (bus.o_sof === 1'b1) begin t_sof_cnt++; t_sof_idx = t_beats; end
      if (bus.o_eof === 1'b1) begin t_eof_cnt++; t_eof_idx = t_beats; end
      t_beats++;
    end
  end

  initial begin
    bus.i_valid = 1'b0; bus.i_sof = 1'b0; bus.i_red = '0; bus.i_green = '0; bus.i_blue = '0;
    bus.i_threshold = '0; bus.i_invert = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // beats without sof while idle are dropped
    repeat (3) drive_cycle(1'b1, 1'b0, 1023, 1023, 1023, 0, 1'b0);

    clear_tally();
    send_frame(0, 0, 1'b0, 0, -1, 1'b0);
    check_vec("white_vec", t_vec, WHITE);
    check("white_ones", t_ones, 44);
    check("white_beats", t_beats, 48);
    check("white_sof_idx", t_sof_idx, 0);
    check("white_eof_idx", t_eof_idx, 47);
    check("white_eof_cnt", t_eof_cnt, 1);

    clear_tally();
    send_frame(1, 512, 1'b0, 0, -1, 1'b0);
    check_vec("single_vec", t_vec, 64'd0);
    check("single_beats", t_beats, 48);

    clear_tally();
    send_frame(2, 512, 1'b0, 0, -1, 1'b0);
    check_vec("square_vec", t_vec, PLUS);

    clear_tally();
    send_frame(3, 512, 1'b0, 0, -1, 1'b0);
    check_vec("u512_thr512", t_vec, WHITE);
    clear_tally();
    send_frame(3, 513, 1'b0, 0, -1, 1'b0);
    check_vec("u512_thr513", t_vec, 64'd0);
    clear_tally();
    send_frame(3, 513, 1'b1, 0, -1, 1'b0);
    check_vec("u512_thr513_inv", t_vec, WHITE);

    clear_tally();
    send_frame(0, 0, 1'b0, 1, -1, 1'b1);
    check("gap_beats", t_beats, 48);
    check("gap_busy", t_busy, 9);
    check("gap_busy_valid", t_busy_valid, 9);
    check_vec("gap_vec", t_vec, WHITE);

    send_frame(2, 512, 1'b0, 0, 20, 1'b0);
    do_reset();
    clear_tally();
    send_frame(0, 0, 1'b0, 0, -1, 1'b0);
    check("rst_eof_cnt", t_eof_cnt, 1);
    check("rst_beats", t_beats, 48);
    check_vec("rst_vec", t_vec, WHITE);

    send_frame(2, 512, 1'b0, 0, 30, 1'b0);
    clear_tally();
    send_frame(0, 0, 1'b0, 0, -1, 1'b0);
    check("sof_abort_eof_cnt", t_eof_cnt, 1);
    check("sof_abort_sof_cnt", t_sof_cnt, 1);
    check("sof_abort_beats", t_beats, 48);
    check_vec("sof_abort_vec", t_vec, WHITE);

    // reset landing inside the flush: nothing more until the next frame
    send_frame(0, 0, 1'b0, 0, TOTAL, 1'b0);
    drive_cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    do_reset();
    clear_tally();
    repeat (5) idle_cycle();
    check("flush_rst_quiet", t_beats, 0);

    for (int f = 0; f < 3; f++) begin
      clear_tally();
      send_frame(4, $urandom_range(400, 620), 1'($urandom_range(0, 1)), 2, -1, 1'b1);
      check("rand_beats", t_beats, 48);
      check("rand_eof_cnt", t_eof_cnt, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
